// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared encodings and defaults for the two-master memory bus arbiter
package mem_bus_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;
   localparam logic [15:0] ROM_LIMIT_DEF = 16'h0100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_DMA  = 2'd2
   } grant_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// rtl/mem_bus_arbiter_rr_arb2.sv - combinational two-requester round-robin picker (bit0 CPU, bit1 DMA)
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_winner,
   output logic [1:0] win
);

   // last_winner=1 means DMA won last, so on a tie the CPU goes next
   always_comb begin
      win = req;
      if (req == 2'b11) begin
         win = last_winner ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - CPU/DMA bus arbiter driving single-cycle transfers with ROM write protection
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter int                DATA_W    = DATA_W_DEF,
   parameter logic [ADDR_W-1:0] ROM_LIMIT = ROM_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic              rom_sel,
   output logic              ram_sel,
   output logic [1:0]        grant,
   output logic              wr_fault
);

   state_t            state, state_d;
   grant_t            owner;
   logic              last_dma;
   logic [1:0]        win;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              lat_rom;
   logic              fault;

   assign lat_rom = (lat_addr < ROM_LIMIT);
   assign grant   = owner;

   rr_arb2 u_arb (
      .req         ({dma_req, cpu_req}),
      .last_winner (last_dma),
      .win         (win)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         owner     <= GNT_NONE;
         last_dma  <= 1'b1;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         fault     <= 1'b0;
         cpu_rdata <= '0;
         dma_rdata <= '0;
      end else begin
         state <= state_d;
         case (state)
            ST_IDLE: begin
               if (win != 2'b00) begin
                  owner     <= win[0] ? GNT_CPU : GNT_DMA;
                  last_dma  <= win[1];
                  lat_we    <= win[0] ? cpu_we    : dma_we;
                  lat_addr  <= win[0] ? cpu_addr  : dma_addr;
                  lat_wdata <= win[0] ? cpu_wdata : dma_wdata;
                  fault     <= 1'b0;
               end
            end
            ST_XFER: begin
               fault <= lat_we && lat_rom;
               if (!lat_we) begin
                  if (owner == GNT_CPU) cpu_rdata <= mem_rdata;
                  else                  dma_rdata <= mem_rdata;
               end
            end
            ST_ACK: owner <= GNT_NONE;
            default: owner <= GNT_NONE;
         endcase
      end
   end

   always_comb begin
      state_d   = state;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      rom_sel   = 1'b0;
      ram_sel   = 1'b0;
      cpu_ack   = 1'b0;
      dma_ack   = 1'b0;
      wr_fault  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (win != 2'b00) state_d = ST_XFER;
         end
         ST_XFER: begin
            state_d   = ST_ACK;
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            mem_read  = !lat_we;
            // a write below ROM_LIMIT never strobes; it is reported at ack instead
            mem_write = lat_we && !lat_rom;
            rom_sel   = lat_rom;
            ram_sel   = !lat_rom;
         end
         ST_ACK: begin
            state_d  = ST_IDLE;
            cpu_ack  = (owner == GNT_CPU);
            dma_ack  = (owner == GNT_DMA);
            wr_fault = fault;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized self-checking bench for mem_bus_arbiter against a transaction model
module tb_mem_bus_arbiter;

   localparam logic [15:0] LIM = 16'h0100;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [15:0] cpu_addr, dma_addr;
   logic [7:0]  cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
   logic        cpu_ack, dma_ack;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        mem_read, mem_write, rom_sel, ram_sel, wr_fault;
   logic [1:0]  grant;

   always #5 clk = ~clk;

   mem_bus_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .rom_sel(rom_sel), .ram_sel(ram_sel),
      .grant(grant), .wr_fault(wr_fault)
   );

   logic [7:0] mem     [0:65535];
   logic [7:0] ref_mem [0:65535];

   assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;
   always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

   // transaction model: phase counts cycles since the grant edge (0 = idle)
   int          m_phase, m_owner, m_last;
   logic        m_we, m_fault;
   logic [15:0] m_addr;
   logic [7:0]  m_wdata, m_rd_cpu, m_rd_dma;

   int vectors = 0;
   int miscompares = 0;

   logic [1:0] x_grant;
   logic [3:0] x_stb;
   logic [2:0] a_ack;
   logic [7:0] a_rd;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [15:0] rand_addr();
      case ($urandom_range(0, 5))
         0: return 16'h00FF;
         1: return 16'h0100;
         2: return 16'hFFFF;
         3: return 16'h0000;
         4: return {8'h00, 8'($urandom)};
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic model_edge();
      int w;
      if (reset) begin
         m_phase = 0; m_owner = 0; m_last = 2; m_fault = 1'b0;
         m_rd_cpu = 8'h00; m_rd_dma = 8'h00;
         return;
      end
      if (m_phase == 0) begin
         w = 0;
         if (cpu_req && dma_req) w = (m_last == 1) ? 2 : 1;
         else if (cpu_req)       w = 1;
         else if (dma_req)       w = 2;
         if (w != 0) begin
            m_owner = w; m_last = w; m_phase = 1;
            m_we    = (w == 1) ? cpu_we    : dma_we;
            m_addr  = (w == 1) ? cpu_addr  : dma_addr;
            m_wdata = (w == 1) ? cpu_wdata : dma_wdata;
         end
      end else if (m_phase == 1) begin
         m_fault = m_we && (m_addr < LIM);
         if (!m_we) begin
            if (m_owner == 1) m_rd_cpu = ref_mem[m_addr];
            else              m_rd_dma = ref_mem[m_addr];
         end else if (m_addr >= LIM) begin
            ref_mem[m_addr] = m_wdata;
         end
         m_phase = 2;
      end else begin
         m_phase = 0; m_owner = 0;
      end
   endtask

   task automatic check_outputs();
      logic [27:0] ebus;
      logic [2:0]  eack;
      ebus = '0;
      eack = '0;
      if (m_phase == 1)
         ebus = {m_addr, m_wdata, !m_we, m_we && (m_addr >= LIM), m_addr < LIM, m_addr >= LIM};
      if (m_phase == 2)
         eack = {m_owner == 1, m_owner == 2, m_fault};
      chk("grant", 64'(grant), 64'(m_owner));
      chk("bus", 64'({mem_addr, mem_wdata, mem_read, mem_write, rom_sel, ram_sel}), 64'(ebus));
      chk("ack", 64'({cpu_ack, dma_ack, wr_fault}), 64'(eack));
      chk("rdata", 64'({cpu_rdata, dma_rdata}), 64'({m_rd_cpu, m_rd_dma}));
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_xfer(input bit dma, input logic we, input logic [15:0] a, input logic [7:0] d);
      if (dma) begin dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d; end
      else     begin cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
      cycle();
      x_grant = grant;
      x_stb   = {mem_read, mem_write, rom_sel, ram_sel};
      cycle();
      a_ack = {cpu_ack, dma_ack, wr_fault};
      a_rd  = dma ? dma_rdata : cpu_rdata;
      cpu_req = 1'b0;
      dma_req = 1'b0;
      cycle();
   endtask

   initial begin
      int diffs;
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = pat(16'(i));
         ref_mem[i] = pat(16'(i));
      end
      mem[5] = 8'hA9; ref_mem[5] = 8'hA9;
      m_phase = 0; m_owner = 0; m_last = 2; m_we = 1'b0; m_fault = 1'b0;
      m_addr = '0; m_wdata = '0; m_rd_cpu = '0; m_rd_dma = '0;
      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      cycle();
      cycle();
      reset = 1'b0;
      cycle();

      do_xfer(1'b0, 1'b0, 16'h0005, 8'h00);
      chk("t1_xfer", 64'({x_grant, x_stb}), 64'({2'd1, 4'b1010}));
      chk("t1_ack", 64'(a_ack), 64'(3'b100));
      chk("t1_rdata", 64'(a_rd), 64'(8'hA9));

      do_xfer(1'b1, 1'b1, 16'h0200, 8'h3C);
      chk("t2_xfer", 64'({x_grant, x_stb}), 64'({2'd2, 4'b0101}));
      chk("t2_ack", 64'(a_ack), 64'(3'b010));
      chk("t2_mem", 64'(mem[16'h0200]), 64'(8'h3C));

      do_xfer(1'b0, 1'b1, 16'h0010, 8'h77);
      chk("t4_xfer", 64'(x_stb), 64'(4'b0010));
      chk("t4_ack", 64'(a_ack), 64'(3'b101));
      chk("t4_mem", 64'(mem[16'h0010]), 64'(pat(16'h0010)));

      reset = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0120;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0040;
      cycle();
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         cycle();
         if (k % 3 == 0) chk("t3_order", 64'(grant), 64'(((k / 3) % 2 == 0) ? 1 : 2));
      end
      cpu_req = 1'b0;
      dma_req = 1'b0;
      cycle();

      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300;
      cycle();
      reset = 1'b1;
      cycle();
      chk("t5_abort", 64'({grant, dma_ack, mem_read, mem_write}), 64'(0));
      reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0400;
      cycle();
      chk("t5_tie", 64'(grant), 64'(1));
      cycle();
      cpu_req = 1'b0;
      dma_req = 1'b0;
      cycle();

      do_xfer(1'b0, 1'b0, 16'h00FF, 8'h00);
      chk("t6_00ff", 64'(x_stb), 64'(4'b1010));
      do_xfer(1'b0, 1'b0, 16'h0100, 8'h00);
      chk("t6_0100", 64'(x_stb), 64'(4'b1001));
      do_xfer(1'b1, 1'b1, 16'hFFFF, 8'hC5);
      chk("t6_ffff", 64'({x_stb, a_ack}), 64'({4'b0101, 3'b010}));
      chk("t6_mem", 64'(mem[16'hFFFF]), 64'(8'hC5));

      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 39) == 0);
         if (m_phase == 1 && m_owner == 1) begin
            cpu_addr = rand_addr(); cpu_wdata = 8'($urandom);
         end else if (!cpu_req || (m_phase == 2 && m_owner == 1)) begin
            cpu_req = ($urandom_range(0, 2) != 0); cpu_we = 1'($urandom);
            cpu_addr = rand_addr(); cpu_wdata = 8'($urandom);
         end
         if (m_phase == 1 && m_owner == 2) begin
            dma_addr = rand_addr(); dma_wdata = 8'($urandom);
         end else if (!dma_req || (m_phase == 2 && m_owner == 2)) begin
            dma_req = ($urandom_range(0, 2) != 0); dma_we = 1'($urandom);
            dma_addr = rand_addr(); dma_wdata = 8'($urandom);
         end
         cycle();
      end

      diffs = 0;
      for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diffs++;
      chk("mem_image", 64'(diffs), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
